// File: rtl/mem_map_pkg.sv
// Address map, read-back constants and decode helper for the memory responder.
package mem_map_pkg;

    localparam logic [31:0] PERIPH_BASE      = 32'h8000_0000;
    localparam logic [31:0] GPIO_OUT_ADDR    = PERIPH_BASE + 32'h0000_0000;
    localparam logic [31:0] GPIO_IN_ADDR     = PERIPH_BASE + 32'h0000_0004;
    localparam logic [31:0] CYCLE_ADDR       = PERIPH_BASE + 32'h0000_0008;
    localparam logic [31:0] FAULT_ADDR_ADDR  = PERIPH_BASE + 32'h0000_000C;
    localparam logic [31:0] STATUS_ADDR      = PERIPH_BASE + 32'h0000_0010;

    // Value returned to the datapath when a read faults.
    localparam logic [31:0] FAULT_READ_VALUE = 32'h0000_0000;

    typedef enum logic [1:0] {
        SEL_RAM,
        SEL_PERIPH,
        SEL_NONE
    } sel_e;

    // Region decode on the full byte address; alignment is checked separately.
    function automatic sel_e decode_sel(input logic [31:0] addr, input logic [31:0] ram_bytes);
        if (addr < ram_bytes) begin
            return SEL_RAM;
        end else if (addr inside {GPIO_OUT_ADDR, GPIO_IN_ADDR, CYCLE_ADDR,
                                  FAULT_ADDR_ADDR, STATUS_ADDR}) begin
            return SEL_PERIPH;
        end
        return SEL_NONE;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous inputs, synchronous active-low reset.
module sync2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Shift the input through two stages; the first may go metastable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            // NOTE: non-blocking so both stages see the pre-edge values and form a real 2-stage pipe.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/memory_responder.sv
// Memory-side responder: word RAM plus GPIO / cycle / fault peripheral page.
module memory_responder
    import mem_map_pkg::*;
#(
    parameter int MEM_WORDS  = 256,
    parameter int GPIO_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  memory_read,
    input  logic                  memory_write,
    input  logic [31:0]           address,
    input  logic [31:0]           write_data,
    output logic [31:0]           read_data,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic                  access_fault
);

    localparam int          AW        = $clog2(MEM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(MEM_WORDS * 4);

    logic [31:0]           ram [MEM_WORDS];
    logic [AW-1:0]         ram_idx;
    logic [GPIO_WIDTH-1:0] gpio_sync;
    logic [31:0]           cycle_count;
    logic [31:0]           fault_addr;
    sel_e                  sel;
    logic                  fault;
    logic                  ram_we;
    logic [31:0]           read_mux;

    sync2 #(.WIDTH(GPIO_WIDTH)) u_gpio_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (gpio_in),
        .q     (gpio_sync)
    );

    assign ram_idx = address[AW+1:2];

    // Decode the request, flag faults and select the read-back word.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        sel      = decode_sel(address, RAM_BYTES);
        fault    = (memory_read && memory_write) ||
                   ((memory_read || memory_write) &&
                    ((address[1:0] != 2'b00) || (sel == SEL_NONE)));
        ram_we   = memory_write && !fault && (sel == SEL_RAM);
        read_mux = '0;
        if (sel == SEL_RAM) begin
            read_mux = ram[ram_idx];
        end else begin
            case (address)
                GPIO_OUT_ADDR:   read_mux[GPIO_WIDTH-1:0] = gpio_out;
                GPIO_IN_ADDR:    read_mux[GPIO_WIDTH-1:0] = gpio_sync;
                CYCLE_ADDR:      read_mux = cycle_count;
                FAULT_ADDR_ADDR: read_mux = fault_addr;
                STATUS_ADDR:     read_mux[0] = access_fault;
                default:         read_mux = '0;
            endcase
        end
    end

    // RAM write port; reads are taken combinationally by the decode block.
    always_ff @(posedge clk) begin
        // NOTE: the RAM array has no reset so it maps onto block memory; contents stay undefined until written.
        if (rst_n && ram_we) begin
            ram[ram_idx] <= write_data;
        end
    end

    // Registered read data, peripheral registers, fault capture and cycle counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            read_data    <= '0;
            gpio_out     <= '0;
            access_fault <= 1'b0;
            fault_addr   <= '0;
            cycle_count  <= '0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
            if (fault) begin
                if (memory_read) begin
                    read_data <= FAULT_READ_VALUE;
                end
                access_fault <= 1'b1;
                if (!access_fault) begin
                    fault_addr <= address;
                end
            end else if (memory_read) begin
                read_data <= read_mux;
            end else if (memory_write && (sel == SEL_PERIPH)) begin
                case (address)
                    GPIO_OUT_ADDR: gpio_out <= write_data[GPIO_WIDTH-1:0];
                    STATUS_ADDR:   if (write_data[0]) access_fault <= 1'b0;
                    default:       ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_memory_responder.sv
// Self-checking bench for memory_responder: directed test-plan steps plus a random phase
// compared against a transaction-level reference model.
module tb_memory_responder;

    localparam int MW = 256;
    localparam int GW = 8;

    localparam logic [31:0] A_GPO  = 32'h8000_0000;
    localparam logic [31:0] A_GPI  = 32'h8000_0004;
    localparam logic [31:0] A_CYC  = 32'h8000_0008;
    localparam logic [31:0] A_FADR = 32'h8000_000C;
    localparam logic [31:0] A_STAT = 32'h8000_0010;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          memory_read = 1'b0;
    logic          memory_write = 1'b0;
    logic [31:0]   address = '0;
    logic [31:0]   write_data = '0;
    logic [31:0]   read_data;
    logic [GW-1:0] gpio_in = '0;
    logic [GW-1:0] gpio_out;
    logic          access_fault;

    memory_responder #(.MEM_WORDS(MW), .GPIO_WIDTH(GW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .memory_read  (memory_read),
        .memory_write (memory_write),
        .address      (address),
        .write_data   (write_data),
        .read_data    (read_data),
        .gpio_in      (gpio_in),
        .gpio_out     (gpio_out),
        .access_fault (access_fault)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [31:0]   m_mem [int unsigned];
    logic [31:0]   m_rd;
    logic [GW-1:0] m_gpo;
    logic          m_fault;
    logic [31:0]   m_faddr;
    logic [31:0]   m_cycle;
    logic [GW-1:0] m_hist [$];   // gpio_in as seen at each edge, newest last

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic bit is_periph(input logic [31:0] a);
        return a == A_GPO || a == A_GPI || a == A_CYC || a == A_FADR || a == A_STAT;
    endfunction

    // Apply one edge's worth of request to the model, using the rules of the address map.
    task automatic model_edge(input logic r, input logic rd, input logic wr,
                              input logic [31:0] a, input logic [31:0] wd);
        bit bad;
        if (!r) begin
            m_rd = '0; m_gpo = '0; m_fault = 1'b0; m_faddr = '0; m_cycle = '0;
            m_hist.push_back('0);   // reset clears both synchronizer stages
            m_hist.push_back('0);
        end else begin
            bad = (rd && wr) ||
                  ((rd || wr) && (a[1:0] != 2'b00 || !(a < MW * 4 || is_periph(a))));
            if (bad) begin
                if (rd) m_rd = '0;
                if (!m_fault) m_faddr = a;
                m_fault = 1'b1;
            end else if (rd) begin
                if (a < MW * 4)        m_rd = m_mem[a >> 2];
                else if (a == A_GPO)   m_rd = 32'(m_gpo);
                else if (a == A_GPI)   m_rd = 32'(m_hist[$-1]);
                else if (a == A_CYC)   m_rd = m_cycle;
                else if (a == A_FADR)  m_rd = m_faddr;
                else                   m_rd = {31'b0, m_fault};
            end else if (wr) begin
                if (a < MW * 4)                 m_mem[a >> 2] = wd;
                else if (a == A_GPO)            m_gpo = wd[GW-1:0];
                else if (a == A_STAT && wd[0])  m_fault = 1'b0;
            end
            m_cycle = m_cycle + 32'd1;
            m_hist.push_back(gpio_in);
        end
        while (m_hist.size() > 4) void'(m_hist.pop_front());
    endtask

    // One clock: drive, advance the model, then compare all outputs after the edge.
    task automatic step(input logic r, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd);
        rst_n = r; memory_read = rd; memory_write = wr; address = a; write_data = wd;
        model_edge(r, rd, wr, a, wd);
        @(posedge clk);
        #1;
        check("read_data", read_data, m_rd);
        check("gpio_out", 32'(gpio_out), 32'(m_gpo));
        check("access_fault", 32'(access_fault), 32'(m_fault));
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    logic [31:0] pool [8] = '{32'h0, 32'h4, 32'h10, 32'h20, 32'h40, 32'h100, 32'h200, 32'h3FC};
    logic [31:0] bad_addr [5] = '{32'h0000_0402, 32'h9000_0000, 32'h0000_0400,
                                  32'h8000_0014, 32'h8000_0002};

    initial begin
        logic [31:0] c1;
        logic [31:0] c2;
        int          k;
        int          pick;
        logic [31:0] a;

        // Reset with both strobes high: nothing but reset values.
        step(1'b0, 1'b1, 1'b1, 32'h10, 32'hDEAD_0000);
        step(1'b0, 1'b1, 1'b1, 32'h10, 32'hDEAD_0000);
        check("reset_read_data", read_data, 32'h0);
        check("reset_gpio_out", 32'(gpio_out), 32'h0);
        check("reset_fault", 32'(access_fault), 32'h0);

        // A word written before a reset survives a reset with write strobe high.
        step(1'b1, 1'b0, 1'b1, 32'h40, 32'h1111_1111);
        step(1'b0, 1'b0, 1'b1, 32'h40, 32'hBAD0_BAD0);
        step(1'b0, 1'b0, 1'b1, 32'h40, 32'hBAD0_BAD0);
        step(1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
        check("reset_no_ram_write", read_data, 32'h1111_1111);

        // Write then read back; read data holds through idle cycles.
        step(1'b1, 1'b0, 1'b1, 32'h10, 32'h1234_5678);
        step(1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
        check("ram_readback", read_data, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            idle();
            check("read_hold", read_data, 32'h1234_5678);
        end

        // GPIO output register.
        step(1'b1, 1'b0, 1'b1, A_GPO, 32'h0000_00A5);
        check("gpio_out_write", 32'(gpio_out), 32'hA5);
        step(1'b1, 1'b1, 1'b0, A_GPO, 32'h0);
        check("gpio_out_readback", read_data, 32'hA5);

        // Cycle counter: two reads five edges apart differ by five.
        step(1'b1, 1'b1, 1'b0, A_CYC, 32'h0);
        c1 = read_data;
        for (int i = 0; i < 4; i++) idle();
        step(1'b1, 1'b1, 1'b0, A_CYC, 32'h0);
        c2 = read_data;
        check("cycle_delta", c2 - c1, 32'd5);

        // Misaligned read faults and captures the address; a second fault does not overwrite it.
        step(1'b1, 1'b1, 1'b0, 32'h0000_0402, 32'h0);
        check("misaligned_rd", read_data, 32'h0);
        check("misaligned_flag", 32'(access_fault), 32'h1);
        step(1'b1, 1'b1, 1'b0, A_FADR, 32'h0);
        check("fault_addr_first", read_data, 32'h0000_0402);
        step(1'b1, 1'b0, 1'b1, 32'h9000_0000, 32'h5555_5555);
        step(1'b1, 1'b1, 1'b0, A_FADR, 32'h0);
        check("fault_addr_sticky", read_data, 32'h0000_0402);
        step(1'b1, 1'b0, 1'b1, A_STAT, 32'h1);
        check("status_clear", 32'(access_fault), 32'h0);
        step(1'b1, 1'b1, 1'b0, A_STAT, 32'h0);
        check("status_read", read_data, 32'h0);

        // Both strobes high on a preloaded word: fault, no write.
        step(1'b1, 1'b0, 1'b1, 32'h20, 32'hCAFE_0001);
        step(1'b1, 1'b1, 1'b1, 32'h20, 32'hFFFF_FFFF);
        check("both_strobes_flag", 32'(access_fault), 32'h1);
        step(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
        check("both_strobes_no_write", read_data, 32'hCAFE_0001);
        step(1'b1, 1'b1, 1'b0, A_FADR, 32'h0);
        check("fault_addr_both", read_data, 32'h0000_0020);
        step(1'b1, 1'b0, 1'b1, A_STAT, 32'h1);

        // GPIO input synchronizer latency.
        gpio_in = 8'h81;
        for (int i = 0; i < 3; i++) idle();
        gpio_in = 8'h3C;
        idle();
        step(1'b1, 1'b1, 1'b0, A_GPI, 32'h0);
        check("gpio_in_1edge", read_data, 32'h81);
        step(1'b1, 1'b1, 1'b0, A_GPI, 32'h0);
        check("gpio_in_2edge", read_data, 32'h3C);

        // Random phase: preload the address pool, then mix reads, writes and faults.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, pool[i], $urandom);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) gpio_in = GW'($urandom);
            pick = int'($urandom_range(0, 9));
            k    = int'($urandom_range(0, 7));
            case (pick)
                0, 1:    step(1'b1, 1'b1, 1'b0, pool[k], 32'h0);
                2, 3:    step(1'b1, 1'b0, 1'b1, pool[k], $urandom);
                4: begin
                    a = A_GPO + 32'(4 * $urandom_range(0, 4));
                    step(1'b1, 1'b1, 1'b0, a, 32'h0);
                end
                5: begin
                    a = A_GPO + 32'(4 * $urandom_range(0, 4));
                    step(1'b1, 1'b0, 1'b1, a, $urandom);
                end
                6:       step(1'b1, $urandom_range(0, 1) == 1, 1'b1, bad_addr[k % 5], $urandom);
                7:       step(1'b1, 1'b1, 1'b0, bad_addr[k % 5], 32'h0);
                8:       step(1'b1, 1'b0, 1'b1, A_STAT, $urandom);
                default: idle();
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
